// File: rtl/edram_axi_pkg.sv
// edram_axi_pkg: shared types and constants for the external-DRAM AXI4-Lite bridge.
package edram_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_ACK   = 3'd5
  } edram_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/edram_axi_bridge.sv
// edram_axi_bridge: turns single-word enable/RD/WR/BE/addr requests into single-beat
// AXI4-Lite master transactions; returns read data with a one-cycle ack.
// Build option EDRAM_WBUF_EN: posted writes through a one-entry buffer (ack right after
// acceptance, AW/W/B complete in the background, new requests stall until B is taken).
module edram_axi_bridge
  import edram_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_MASK = 32'h0FFF_FFFC,
  parameter logic [2:0]  AXI_PROT  = 3'b000,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        enable,
  input  logic        RD,
  input  logic        WR,
  input  logic [3:0]  BE,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack,
  output logic        busy,
  output logic        err,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  edram_state_t state;
  logic aw_done, w_done, wr_active;
  logic aw_ok, w_ok, b_fire, r_fire;
  logic req_ok, wr_start, rd_start;

  // Handshake qualifiers and request acceptance; WR wins when RD and WR are both set.
  always_comb begin
    aw_ok  = aw_done | (awvalid & awready);
    w_ok   = w_done  | (wvalid & wready);
    b_fire = bvalid & bready;
    r_fire = rvalid & rready;
`ifdef EDRAM_WBUF_EN
    req_ok = (state == ST_IDLE) & enable & ~wr_active;
`else
    req_ok = (state == ST_IDLE) & enable;
`endif
    wr_start = req_ok & WR;
    rd_start = req_ok & RD & ~WR;
  end

  assign ack    = (state == ST_ACK);
`ifdef EDRAM_WBUF_EN
  assign busy   = (state != ST_IDLE) | wr_active;
`else
  assign busy   = (state != ST_IDLE);
`endif
  assign awprot = AXI_PROT;
  assign arprot = AXI_PROT;

  // Write channel engine: AW and W retire independently, B is taken once both are done.
  // Shared by both builds; the FSM either waits on it or lets it run in the background.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wr_active <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
    end else if (wr_start) begin
      awvalid   <= 1'b1;
      wvalid    <= 1'b1;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wr_active <= 1'b1;
      awaddr    <= addr & ADDR_MASK;
      wdata     <= data_i;
      wstrb     <= BE;
    end else if (wr_active) begin
      if (awvalid && awready) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (wvalid && wready) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
      if (!bready && aw_ok && w_ok) bready <= 1'b1;
      if (b_fire) begin
        bready    <= 1'b0;
        wr_active <= 1'b0;
      end
    end
  end

  // Request FSM, read channels, read-data register and sticky error flag.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state   <= ST_IDLE;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      araddr  <= '0;
      data_o  <= '0;
      err     <= 1'b0;
    end else begin
      if (b_fire && (bresp != AXI_RESP_OKAY)) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (wr_start) begin
`ifdef EDRAM_WBUF_EN
            state <= ST_ACK;
`else
            state <= ST_WADDR;
`endif
          end else if (rd_start) begin
            arvalid <= 1'b1;
            araddr  <= addr & ADDR_MASK;
            state   <= ST_RADDR;
          end
        end
        ST_WADDR: if (aw_ok && w_ok) state <= ST_WRESP;
        ST_WRESP: if (b_fire) state <= ST_ACK;
        ST_RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (r_fire) begin
            rready <= 1'b0;
            data_o <= (rresp == AXI_RESP_OKAY) ? rdata : ERR_DATA;
            if (rresp != AXI_RESP_OKAY) err <= 1'b1;
            state  <= ST_ACK;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edram_axi_bridge.sv
// tb_edram_axi_bridge: scoreboard bench for edram_axi_bridge with an AXI4-Lite slave
// model and a word-memory reference model. Honours EDRAM_WBUF_EN when defined.
`timescale 1ns/1ps
module tb_edram_axi_bridge;

  localparam logic [31:0] MASK = 32'h0FFF_FFFC;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef EDRAM_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic        XCLK = 1'b0;
  logic        XRES;
  logic        enable, RD, WR;
  logic [3:0]  BE;
  logic [31:0] addr, data_i, data_o;
  logic        ack, busy, err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic [1:0]  bresp, rresp;

  always #5 XCLK = ~XCLK;

  edram_axi_bridge #(
    .ADDR_MASK(32'h0FFF_FFFC),
    .AXI_PROT (3'b000),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .XCLK(XCLK), .XRES(XRES), .enable(enable), .RD(RD), .WR(WR), .BE(BE),
    .addr(addr), .data_i(data_i), .data_o(data_o), .ack(ack), .busy(busy), .err(err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // ---------------- AXI4-Lite slave model ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic have_aw, have_w, have_ar;
  logic [31:0] s_awaddr, s_wdata, s_araddr, sa, sd, ra;
  logic [3:0]  s_wstrb, ss;
  logic [31:0] smem [logic [31:0]];
  logic [1:0]  bresp_q[$], rresp_q[$];
  logic [1:0]  pr;

  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid  && (w_wait  >= w_dly);
  assign arready = arvalid && (ar_wait >= ar_dly);

  function automatic logic [31:0] bmerge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[i*8 +: 8] = d[i*8 +: 8];
    return o;
  endfunction

  always @(posedge XCLK) begin
    if (XRES) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
      have_aw <= 1'b0; have_w <= 1'b0; have_ar <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
    end else begin
      if (awvalid && awready) aw_wait <= 0; else if (awvalid) aw_wait <= aw_wait + 1;
      if (wvalid && wready)   w_wait  <= 0; else if (wvalid)  w_wait  <= w_wait + 1;
      if (arvalid && arready) ar_wait <= 0; else if (arvalid) ar_wait <= ar_wait + 1;
      if (awvalid && awready) begin have_aw <= 1'b1; s_awaddr <= awaddr; end
      if (wvalid && wready)   begin have_w <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
      if (arvalid && arready) begin have_ar <= 1'b1; s_araddr <= araddr; end
      if (bvalid && bready) bvalid <= 1'b0;
      else if (!bvalid && (have_aw || (awvalid && awready)) && (have_w || (wvalid && wready))) begin
        if (b_wait >= b_dly) begin
          sa = have_aw ? s_awaddr : awaddr;
          sd = have_w ? s_wdata : wdata;
          ss = have_w ? s_wstrb : wstrb;
          smem[sa] = bmerge(smem.exists(sa) ? smem[sa] : 32'h0, sd, ss);
          pr = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
          bvalid <= 1'b1; bresp <= pr;
          have_aw <= 1'b0; have_w <= 1'b0; b_wait <= 0;
        end else b_wait <= b_wait + 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      else if (!rvalid && (have_ar || (arvalid && arready))) begin
        if (r_wait >= r_dly) begin
          ra = have_ar ? s_araddr : araddr;
          pr = (rresp_q.size() > 0) ? rresp_q.pop_front() : 2'b00;
          rvalid <= 1'b1; rresp <= pr;
          rdata  <= (pr == 2'b00) ? (smem.exists(ra) ? smem[ra] : 32'h0) : 32'h0BAD_F00D;
          have_ar <= 1'b0; r_wait <= 0;
        end else r_wait <= r_wait + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        chk_err;
    logic        err;
    logic [31:0] data;
  } ack_t;

  logic [31:0] exp_aw_q[$], exp_ar_q[$];
  logic [35:0] exp_w_q[$];
  ack_t        exp_ack_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic        exp_err;
  logic [31:0] last_rd;
  logic        ack_prev = 1'b0;
  ack_t        ea;
  logic [35:0] ew;

  always @(negedge XCLK) begin
    if (!XRES) begin
      if (awvalid && awready) begin
        if (exp_aw_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL aw_unexpected: got awaddr %h, expected no write", awaddr);
        end else check("awaddr", awaddr, exp_aw_q.pop_front());
      end
      if (wvalid && wready) begin
        if (exp_w_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL w_unexpected: got wdata %h, expected no write", wdata);
        end else begin
          ew = exp_w_q.pop_front();
          check("wdata", wdata, ew[31:0]);
          check("wstrb", {28'h0, wstrb}, {28'h0, ew[35:32]});
        end
      end
      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL ar_unexpected: got araddr %h, expected no read", araddr);
        end else check("araddr", araddr, exp_ar_q.pop_front());
      end
      if (ack) begin
        check("ack_pulse", {31'h0, ack_prev}, 32'h0);
        check("busy_at_ack", {31'h0, busy}, 32'h1);
        if (exp_ack_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL ack_unexpected: got ack 1, expected 0");
        end else begin
          ea = exp_ack_q.pop_front();
          check("data_o", data_o, ea.data);
          if (ea.chk_err) check("err", {31'h0, err}, {31'h0, ea.err});
        end
      end
      ack_prev <= ack;
    end else ack_prev <= 1'b0;
  end

  // ---------------- stimulus ----------------
  task automatic flush();
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_ack_q.delete();
    bresp_q.delete(); rresp_q.delete();
    exp_err = 1'b0; last_rd = '0;
  endtask

  task automatic check_reset_values();
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_data_o", data_o, 32'h0);
    check("rst_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_wstrb", {28'h0, wstrb}, 32'h0);
  endtask

  task automatic idle(input int n);
    enable = 1'b0; RD = 1'($urandom); WR = 1'($urandom);
    repeat (n) begin @(posedge XCLK); #1; end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] resp, input int exp_lat);
    logic [31:0] m, old, bm;
    ack_t e;
    int n;
    bit got;
    m = a & MASK;
    if (wr) begin
      bresp_q.push_back(resp);
      exp_aw_q.push_back(m);
      exp_w_q.push_back({be, d});
      old = ref_mem.exists(m) ? ref_mem[m] : 32'h0;
      bm  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      ref_mem[m] = (old & ~bm) | (d & bm);
      if (resp != 2'b00) exp_err = 1'b1;
      e = '{chk_err: !WBUF, err: exp_err, data: last_rd};
    end else begin
      rresp_q.push_back(resp);
      exp_ar_q.push_back(m);
      if (resp == 2'b00) last_rd = ref_mem.exists(m) ? ref_mem[m] : 32'h0;
      else begin last_rd = ERRD; exp_err = 1'b1; end
      e = '{chk_err: 1'b1, err: exp_err, data: last_rd};
    end
    exp_ack_q.push_back(e);
    enable = 1'b1; RD = rd; WR = wr; BE = be; addr = a; data_i = d;
    n = 0; got = 0;
    while (!got && n < 200) begin
      @(posedge XCLK); #1; n++;
      if (ack) got = 1;
    end
    if (!got) begin
      n_cmp++; n_bad++; $display("FAIL ack_timeout: got no ack in %0d cycles, expected ack", n);
    end else if (exp_lat >= 0) check("ack_latency", n, exp_lat);
  endtask

  function automatic logic [1:0] rand_resp();
    int r = $urandom_range(0, 19);
    return (r < 2) ? 2'b10 : ((r == 2) ? 2'b11 : 2'b00);
  endfunction

  initial begin
    int op, cnt;
    logic [31:0] a;
    XRES = 1'b1; enable = 1'b0; RD = 1'b0; WR = 1'b0; BE = '0; addr = '0; data_i = '0;
    flush();
    repeat (3) @(posedge XCLK);
    #1;
    check_reset_values();
    XRES = 1'b0;
    idle(2);

    // zero-wait write then read at 0x100
    do_req(1'b0, 1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678, 2'b00, WBUF ? 1 : 3);
    idle(1);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 2'b00, 3);
    idle(1);
    // partial write, W ready three cycles after AW
    w_dly = 3;
    do_req(1'b0, 1'b1, 4'b0011, 32'h0000_0204, 32'hAABB_CCDD, 2'b00, WBUF ? 1 : 6);
    w_dly = 0;
    idle(1);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_0204, 32'h0, 2'b00, -1);
    idle(1);
    // error read, then sticky err across an OKAY read
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 2'b10, -1);
    idle(1);
    do_req(1'b1, 1'b0, 4'h0, 32'hF000_0103, 32'h0, 2'b00, -1);
    idle(1);
    // RD and WR together: write only
    do_req(1'b1, 1'b1, 4'b1100, 32'h0000_0208, 32'h5566_7788, 2'b00, -1);
    idle(1);
`ifdef EDRAM_WBUF_EN
    // posted write with slow B, read issued immediately behind it
    b_dly = 5;
    do_req(1'b0, 1'b1, 4'hF, 32'h0000_0300, 32'hC0FF_EE11, 2'b00, 1);
    b_dly = 0;
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0, 2'b00, -1);
    idle(1);
`endif

    // randomized traffic over a small word pool with random mask-ignored bits
    for (int t = 0; t < 300; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      a  = (32'h0000_0100 + 32'($urandom_range(0, 7)) * 4) | ($urandom & 32'hF000_0003);
      op = $urandom_range(0, 9);
      if (op < 4)      do_req(1'b1, 1'b0, 4'($urandom), a, $urandom, rand_resp(), -1);
      else if (op < 8) do_req(1'b0, 1'b1, 4'($urandom), a, $urandom, rand_resp(), -1);
      else             do_req(1'b1, 1'b1, 4'($urandom), a, $urandom, rand_resp(), -1);
      idle($urandom_range(0, 2));
    end

    // reset in the middle of a read data phase
    idle(1);
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 8;
    cnt = 0;
    while (busy && cnt < 50) begin @(posedge XCLK); #1; cnt++; end
    rresp_q.push_back(2'b00);
    exp_ar_q.push_back(32'h0000_0104);
    enable = 1'b1; RD = 1'b1; WR = 1'b0; addr = 32'h0000_0104;
    cnt = 0;
    while (!rready && cnt < 20) begin @(posedge XCLK); #1; cnt++; end
    check("rready_before_reset", {31'h0, rready}, 32'h1);
    XRES = 1'b1; enable = 1'b0; RD = 1'b0;
    @(posedge XCLK); #1;
    check_reset_values();
    flush();
    r_dly = 0;
    @(posedge XCLK); #1;
    XRES = 1'b0;
    idle(1);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 2'b00, 3);
    idle(1);

    cnt = 0;
    while (busy && cnt < 100) begin @(posedge XCLK); #1; cnt++; end
    repeat (2) @(posedge XCLK);
    #1;
    check("drain_busy", {31'h0, busy}, 32'h0);
    check("left_aw", exp_aw_q.size(), 32'h0);
    check("left_w", exp_w_q.size(), 32'h0);
    check("left_ar", exp_ar_q.size(), 32'h0);
    check("left_ack", exp_ack_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
